// File: rtl/cbx_param_shadow_cfg.sv
// cbx_param_shadow_cfg: X-channel connection block with double-buffered (shadow/active) routing config
module cbx_param_shadow_cfg #(
  parameter int CHAN_W  = 20,
  parameter int NUM_PIN = 16,
  parameter int TAPS    = 5,
  parameter int STRIDE  = 4,
  parameter int SEL_W   = $clog2(2 * TAPS),
  parameter int CFG_B   = SEL_W + 1,
  parameter int CHAIN_L = NUM_PIN * CFG_B
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              ccff_head,
  input  logic              ccff_en,
  input  logic              cfg_commit,
  input  logic [CHAN_W-1:0] chanx_left_in,
  input  logic [CHAN_W-1:0] chanx_right_in,
  output logic [CHAN_W-1:0] chanx_left_out,
  output logic [CHAN_W-1:0] chanx_right_out,
  output logic [NUM_PIN-1:0] bottom_grid_pin,
  output logic              ccff_tail,
  output logic              cfg_full,
  output logic              cfg_err
);
  localparam int CNT_W = $clog2(CHAIN_L + 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_L);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  typedef enum logic [1:0] {IDLE, SHIFT, FULL, OVER} state_t;
  state_t state;
  logic [CHAIN_L-1:0] shadow, active;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic err_n, copy;
  assign chanx_left_out  = chanx_right_in;
  assign chanx_right_out = chanx_left_in;
  assign ccff_tail = shadow[CHAIN_L-1];
  // State is a pure decode of the saturating shift count
  always_comb begin
    state = cnt == '0 ? IDLE : cnt < FULL_CNT ? SHIFT : cnt == FULL_CNT ? FULL : OVER;
  end
  // Next count, commit validity and sticky error
  always_comb begin
    copy  = cfg_commit && state == FULL;
    err_n = cfg_err | (cfg_commit && (state == IDLE || state == SHIFT))
                    | (ccff_en && !cfg_commit && state == FULL);
    cnt_n = cnt;
    if (cfg_commit && (state == FULL || state == OVER))
      cnt_n = ccff_en ? ONE : '0;
    else if (ccff_en && state != OVER)
      cnt_n = cnt + ONE;
  end
  // Shadow chain shifts freely; active only loads on a valid commit (pre-shift shadow)
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      shadow   <= '0;
      active   <= '0;
      cnt      <= '0;
      cfg_err  <= 1'b0;
      cfg_full <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      cfg_err  <= err_n;
      cfg_full <= cnt_n == FULL_CNT;
      if (ccff_en) shadow <= {shadow[CHAIN_L-2:0], ccff_head};
      if (copy) active <= shadow;
    end
  end
  for (genvar p = 0; p < NUM_PIN; p++) begin : g_pin
    logic [2**SEL_W-1:0] m;
    logic [SEL_W-1:0] sel;
    logic en;
    assign sel = active[p*CFG_B +: SEL_W];
    assign en  = active[p*CFG_B + SEL_W];
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
      localparam int T = (p + k * STRIDE) % CHAN_W;
      assign m[2*k]   = chanx_left_in[T];
      assign m[2*k+1] = chanx_right_in[T];
    end
    if (2**SEL_W > 2 * TAPS) begin : g_pad
      assign m[2**SEL_W-1:2*TAPS] = '0;
    end
    // Out-of-range selects land on the zero padding
    assign bottom_grid_pin[p] = en & m[sel];
  end
endmodule

// File: tb/tb_cbx_param_shadow_cfg.sv
// tb_cbx_param_shadow_cfg: scoreboard bench for the shadow-configured connection block
module tb_cbx_param_shadow_cfg;
  logic prog_clk = 0, prog_reset_n = 0, ccff_head = 0, ccff_en = 0, cfg_commit = 0;
  logic [19:0] left_in = '0, right_in = '0, left_out, right_out;
  logic [15:0] pins;
  logic ccff_tail, cfg_full, cfg_err;
  int checks = 0, failures = 0;
  logic [79:0] m_shadow = '0, m_active = '0;
  int m_cnt = 0;
  logic m_err = 0;
  typedef struct packed {logic tail; logic full; logic err; logic [15:0] pins;} exp_t;
  exp_t q[$];

  cbx_param_shadow_cfg dut (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .ccff_head(ccff_head),
    .ccff_en(ccff_en), .cfg_commit(cfg_commit), .chanx_left_in(left_in),
    .chanx_right_in(right_in), .chanx_left_out(left_out), .chanx_right_out(right_out),
    .bottom_grid_pin(pins), .ccff_tail(ccff_tail), .cfg_full(cfg_full), .cfg_err(cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  function automatic logic [15:0] exp_pins(input logic [79:0] a, input logic [19:0] l, input logic [19:0] r);
    logic [15:0] res;
    logic [3:0] s;
    int t;
    res = '0;
    for (int p = 0; p < 16; p++) begin
      s = a[p*5 +: 4];
      if (a[p*5+4] && s < 10) begin
        t = (p + int'(s >> 1) * 4) % 20;
        res[p] = s[0] ? r[t] : l[t];
      end
    end
    return res;
  endfunction

  task automatic step(input logic en, input logic head, input logic commit);
    exp_t e, got;
    ccff_en = en; ccff_head = head; cfg_commit = commit;
    if (commit) begin
      if (m_cnt == 80) begin m_active = m_shadow; m_cnt = en ? 1 : 0; end
      else if (m_cnt == 81) m_cnt = en ? 1 : 0;
      else begin m_err = 1; if (en) m_cnt++; end
    end else if (en) begin
      if (m_cnt == 80) begin m_err = 1; m_cnt = 81; end
      else if (m_cnt < 80) m_cnt++;
    end
    if (en) m_shadow = {m_shadow[78:0], head};
    e = '{tail: m_shadow[79], full: m_cnt == 80, err: m_err, pins: exp_pins(m_active, left_in, right_in)};
    q.push_back(e);
    @(posedge prog_clk); #1;
    ccff_en = 0; cfg_commit = 0;
    e = q.pop_front();
    got = {ccff_tail, cfg_full, cfg_err, pins};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL step cnt=%0d: got tail/full/err/pins=%h required %h", m_cnt, got, e);
    end
  endtask

  task automatic load(input logic [79:0] c);
    for (int i = 79; i >= 0; i--) step(1, c[i], 0);
  endtask

  task automatic do_reset;
    ccff_en = 0; cfg_commit = 0;
    prog_reset_n = 0;
    m_shadow = '0; m_active = '0; m_cnt = 0; m_err = 0;
    @(negedge prog_clk);
    prog_reset_n = 1;
  endtask

  task automatic test_reset;
    left_in = 20'hABCDE; right_in = 20'h12345;
    #2;
    checks++; if (pins !== 16'h0) begin failures++; $display("FAIL reset_pins: got %h required 0", pins); end
    checks++; if ({cfg_err, cfg_full, ccff_tail} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b required 000", {cfg_err, cfg_full, ccff_tail}); end
    checks++; if (right_out !== 20'hABCDE) begin failures++; $display("FAIL right_out: got %h required abcde", right_out); end
    checks++; if (left_out !== 20'h12345) begin failures++; $display("FAIL left_out: got %h required 12345", left_out); end
    do_reset();
  endtask

  task automatic test_load_commit;
    logic [79:0] c = '0;
    c[4:0] = 5'b10011;
    left_in = '0; right_in = '0;
    load(c);
    checks++; if (cfg_full !== 1'b1) begin failures++; $display("FAIL full_before_commit: got %b required 1", cfg_full); end
    step(0, 0, 1);
    for (int v = 0; v < 2; v++) begin
      right_in[4] = v[0]; #1;
      checks++; if (pins !== {15'b0, v[0]}) begin failures++; $display("FAIL pin0_follow: got %h required %h", pins, {15'b0, v[0]}); end
    end
    for (int i = 0; i < 4; i++) begin
      left_in = 20'($urandom); right_in = 20'($urandom); #1;
      checks++; if (pins !== {15'b0, right_in[4]}) begin failures++; $display("FAIL pin0_rand: got %h required %h", pins, {15'b0, right_in[4]}); end
    end
  endtask

  task automatic test_shadow;
    for (int i = 0; i < 40; i++) begin
      right_in[4] = i[0];
      step(1, 1'($urandom), 0);
      checks++; if (pins[0] !== i[0]) begin failures++; $display("FAIL shadow_pin0 %0d: got %b required %b", i, pins[0], i[0]); end
    end
  endtask

  task automatic test_early_commit;
    for (int i = 0; i < 39; i++) step(1, 1'($urandom), 0);
    step(0, 0, 1);
    checks++; if ({cfg_err, cfg_full} !== 2'b10) begin failures++; $display("FAIL early_commit err/full: got %b required 10", {cfg_err, cfg_full}); end
    step(1, 0, 0);
    checks++; if (cfg_full !== 1'b1) begin failures++; $display("FAIL full_after_80: got %b required 1", cfg_full); end
    step(0, 0, 1);
  endtask

  task automatic test_overshift;
    logic [79:0] a = '0, b;
    a[4:0] = 5'b10011;
    b = {$urandom, $urandom, 16'($urandom)};
    do_reset();
    load(a); step(0, 0, 1);
    load(b);
    checks++; if ({cfg_full, cfg_err} !== 2'b10) begin failures++; $display("FAIL at_80 full/err: got %b required 10", {cfg_full, cfg_err}); end
    step(1, 1, 0);
    checks++; if ({cfg_full, cfg_err} !== 2'b01) begin failures++; $display("FAIL at_81 full/err: got %b required 01", {cfg_full, cfg_err}); end
    checks++; if (ccff_tail !== b[78]) begin failures++; $display("FAIL tail_81: got %b required %b", ccff_tail, b[78]); end
    step(0, 0, 1);
    left_in = 20'($urandom); right_in = 20'($urandom); #1;
    checks++; if (pins !== exp_pins(a, left_in, right_in)) begin failures++; $display("FAIL over_commit_nocopy: got %h required %h", pins, exp_pins(a, left_in, right_in)); end
    checks++; if (cfg_full !== 1'b0) begin failures++; $display("FAIL over_commit_full: got %b required 0", cfg_full); end
  endtask

  task automatic test_sel_range;
    logic [79:0] c = '0;
    c[25 +: 5] = 5'b11100;
    c[30 +: 5] = 5'b11001;
    do_reset();
    load(c); step(0, 0, 1);
    left_in = '1; right_in = '1; #1;
    checks++; if (pins[6:5] !== 2'b10) begin failures++; $display("FAIL sel_range pins6:5: got %b required 10", pins[6:5]); end
    right_in[2] = 0; #1;
    checks++; if (pins[6] !== 1'b0) begin failures++; $display("FAIL sel9_track2: got %b required 0", pins[6]); end
  endtask

  task automatic test_commit_shift;
    logic [79:0] d = {$urandom, $urandom, 16'($urandom)};
    left_in = 20'($urandom); right_in = 20'($urandom);
    load(d);
    step(1, 1, 1);
    checks++; if (cfg_full !== 1'b0) begin failures++; $display("FAIL cs_full: got %b required 0", cfg_full); end
    checks++; if (pins !== exp_pins(d, left_in, right_in)) begin failures++; $display("FAIL cs_copy: got %h required %h", pins, exp_pins(d, left_in, right_in)); end
    for (int i = 0; i < 79; i++) step(1, 1'($urandom), 0);
    checks++; if (cfg_full !== 1'b1) begin failures++; $display("FAIL cs_cnt_from_1: got %b required 1", cfg_full); end
  endtask

  task automatic test_async_reset;
    logic [79:0] c = '0;
    c[4:0] = 5'b10011;
    c[79:75] = 5'b10000;
    c[74:70] = 5'b10000;
    do_reset();
    load(c); step(0, 0, 1);
    left_in = '1; right_in = '1;
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 0);
    checks++; if ({pins[15], pins[14], pins[0], cfg_err, ccff_tail} !== 5'b11111) begin failures++; $display("FAIL pre_async: got %b required 11111", {pins[15], pins[14], pins[0], cfg_err, ccff_tail}); end
    ccff_en = 1; ccff_head = 1;
    #2 prog_reset_n = 0;
    #1;
    checks++; if (pins !== 16'h0) begin failures++; $display("FAIL async_pins: got %h required 0", pins); end
    checks++; if ({cfg_err, cfg_full, ccff_tail} !== 3'b000) begin failures++; $display("FAIL async_flags: got %b required 000", {cfg_err, cfg_full, ccff_tail}); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_load_commit();
    test_shadow();
    test_early_commit();
    test_overshift();
    test_sel_range();
    test_commit_shift();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
